// File: rtl/rename_repair_sequencer_pkg.sv
// rtl/rename_repair_sequencer_pkg.sv - shared types, defaults and sizing helpers for the rename repair walk
package rename_repair_sequencer_pkg;

  localparam int SIZE_RMT_DEF          = 34;
  localparam int SIZE_RMT_LOG_DEF      = 6;
  localparam int SIZE_PHYSICAL_LOG_DEF = 7;
  localparam int N_REPAIR_PACKETS_DEF  = 4;

  // Walk states: IDLE, waiting for the AMT RAM, reading beats, emitting the final beat
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RAM = 2'd1,
    READ     = 2'd2,
    DRAIN    = 2'd3
  } repairState_e;

  // One repair lane as seen by the RMT at the default sizing
  typedef struct packed {
    logic [SIZE_RMT_LOG_DEF-1:0]      addr;
    logic [SIZE_PHYSICAL_LOG_DEF-1:0] data;
    logic                             valid;
  } repairPkt;

  // Number of read beats needed to cover every logical register
  function automatic int calcBeats(input int sizeRmt, input int nPkts);
    return (sizeRmt + nPkts - 1) / nPkts;
  endfunction

  // Beat counter width; the counter reaches BEATS once the last read is issued
  function automatic int calcCntWidth(input int sizeRmt, input int nPkts);
    return $clog2(calcBeats(sizeRmt, nPkts) + 1);
  endfunction

  localparam int BEATS_DEF = calcBeats(SIZE_RMT_DEF, N_REPAIR_PACKETS_DEF);
  localparam int CNT_W_DEF = calcCntWidth(SIZE_RMT_DEF, N_REPAIR_PACKETS_DEF);

endpackage

// File: rtl/rename_repair_sequencer_repair_addr_gen.sv
// rtl/rename_repair_sequencer_repair_addr_gen.sv - beat counter to lane addresses and lane-valid mask
module repair_addr_gen
  import rename_repair_sequencer_pkg::*;
#(
  parameter int SIZE_RMT         = SIZE_RMT_DEF,
  parameter int SIZE_RMT_LOG     = SIZE_RMT_LOG_DEF,
  parameter int N_REPAIR_PACKETS = N_REPAIR_PACKETS_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]                             beat,
  output logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0] laneAddr,
  output logic [N_REPAIR_PACKETS-1:0]                   laneValid
);

  // Lane k of beat b covers register b*N+k; lanes past the table read address 0 and are masked
  always_comb begin
    laneAddr  = '0;
    laneValid = '0;
    for (int k = 0; k < N_REPAIR_PACKETS; k++) begin
      if ((int'(beat) * N_REPAIR_PACKETS + k) < SIZE_RMT) begin
        laneValid[k] = 1'b1;
        laneAddr[k]  = SIZE_RMT_LOG'(int'(beat) * N_REPAIR_PACKETS + k);
      end
    end
  end

endmodule

// File: rtl/rename_repair_sequencer.sv
// rtl/rename_repair_sequencer.sv - walks the AMT and replays it into the RMT after recovery (option: REPAIR_PERF_CNT_EN)
module rename_repair_sequencer
  import rename_repair_sequencer_pkg::*;
#(
  parameter int SIZE_RMT          = SIZE_RMT_DEF,
  parameter int SIZE_RMT_LOG      = SIZE_RMT_LOG_DEF,
  parameter int SIZE_PHYSICAL_LOG = SIZE_PHYSICAL_LOG_DEF,
  parameter int N_REPAIR_PACKETS  = N_REPAIR_PACKETS_DEF
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              recoverFlag_i,
  input  logic                                              amtRamReady_i,
  output logic                                              amtReadEn_o,
  output logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0]      amtReadAddr_o,
  input  logic [N_REPAIR_PACKETS-1:0][SIZE_PHYSICAL_LOG-1:0] amtReadData_i,
  output logic                                              repairFlag_o,
  output logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0]      repairAddr_o,
  output logic [N_REPAIR_PACKETS-1:0][SIZE_PHYSICAL_LOG-1:0] repairData_o,
  output logic [N_REPAIR_PACKETS-1:0]                        repairLaneValid_o,
  output logic                                              repairBusy_o,
  output logic                                              repairDone_o
`ifdef REPAIR_PERF_CNT_EN
  ,
  output logic [15:0]                                       repairCount_o,
  output logic [31:0]                                       repairCycles_o
`endif
);

  localparam int BEATS = calcBeats(SIZE_RMT, N_REPAIR_PACKETS);
  localparam int CNT_W = calcCntWidth(SIZE_RMT, N_REPAIR_PACKETS);

  repairState_e state, nextState;
  logic [CNT_W-1:0] beatCnt, beatCntNext;
  logic readEn;
  logic lastBeat;
  logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0] genAddr;
  logic [N_REPAIR_PACKETS-1:0] genValid;
  logic repairFlagQ;
  logic [N_REPAIR_PACKETS-1:0][SIZE_RMT_LOG-1:0] repairAddrQ;
  logic [N_REPAIR_PACKETS-1:0] repairValidQ;

  repair_addr_gen #(
    .SIZE_RMT         (SIZE_RMT),
    .SIZE_RMT_LOG     (SIZE_RMT_LOG),
    .N_REPAIR_PACKETS (N_REPAIR_PACKETS),
    .CNT_W            (CNT_W)
  ) addrGen (
    .beat      (beatCnt),
    .laneAddr  (genAddr),
    .laneValid (genValid)
  );

  assign lastBeat = (beatCnt == CNT_W'(BEATS - 1));

  // State and beat counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state   <= nextState;
      beatCnt <= beatCntNext;
    end
  end

  // Next state and read strobe; a recover request always restarts at beat 0 and
  // suppresses the read that cycle. WAIT_RAM issues the held beat in the very
  // cycle the RAM reports ready, so resuming costs no extra cycle.
  always_comb begin
    nextState   = state;
    beatCntNext = beatCnt;
    readEn      = 1'b0;
    unique case (state)
      IDLE: begin
        beatCntNext = '0;
        if (recoverFlag_i) nextState = amtRamReady_i ? READ : WAIT_RAM;
      end
      WAIT_RAM, READ: begin
        if (recoverFlag_i) begin
          beatCntNext = '0;
          nextState   = amtRamReady_i ? READ : WAIT_RAM;
        end else if (!amtRamReady_i) begin
          nextState = WAIT_RAM;
        end else begin
          readEn      = 1'b1;
          beatCntNext = beatCnt + CNT_W'(1);
          nextState   = lastBeat ? DRAIN : READ;
        end
      end
      DRAIN: begin
        beatCntNext = '0;
        if (recoverFlag_i) nextState = amtRamReady_i ? READ : WAIT_RAM;
        else               nextState = IDLE;
      end
      default: begin
        beatCntNext = '0;
        nextState   = IDLE;
      end
    endcase
  end

  assign amtReadEn_o   = readEn;
  assign amtReadAddr_o = readEn ? genAddr : '0;

  // Address and lane mask follow the AMT read by one cycle to line up with its data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repairFlagQ  <= 1'b0;
      repairAddrQ  <= '0;
      repairValidQ <= '0;
    end else begin
      repairFlagQ  <= readEn;
      repairAddrQ  <= amtReadAddr_o;
      repairValidQ <= readEn ? genValid : '0;
    end
  end

  assign repairFlag_o      = repairFlagQ;
  assign repairAddr_o      = repairAddrQ;
  assign repairLaneValid_o = repairValidQ;
  assign repairData_o      = repairFlagQ ? amtReadData_i : '0;
  assign repairBusy_o      = (state != IDLE);
  assign repairDone_o      = (state == DRAIN);

`ifdef REPAIR_PERF_CNT_EN
  // Saturating counts of walks started and of cycles Rename was held busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repairCount_o  <= '0;
      repairCycles_o <= '0;
    end else begin
      if (recoverFlag_i && (repairCount_o != 16'hFFFF)) repairCount_o <= repairCount_o + 16'd1;
      if (repairBusy_o && (repairCycles_o != 32'hFFFF_FFFF)) repairCycles_o <= repairCycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_repair_sequencer.sv
// tb/tb_rename_repair_sequencer.sv - self-checking bench for rename_repair_sequencer
module tb_rename_repair_sequencer;

  localparam int SIZE_RMT = 34;
  localparam int LOG      = 6;
  localparam int PL       = 7;
  localparam int N        = 4;
  localparam int BEATS    = (SIZE_RMT + N - 1) / N;

  logic clk;
  logic resetN;
  logic recoverFlag, amtRamReady;
  logic amtReadEn;
  logic [N-1:0][LOG-1:0] amtReadAddr;
  logic [N-1:0][PL-1:0]  amtReadData;
  logic repairFlag, repairBusy, repairDone;
  logic [N-1:0][LOG-1:0] repairAddr;
  logic [N-1:0][PL-1:0]  repairData;
  logic [N-1:0]          laneValid;

  logic recover1, ready1;
  logic amtReadEn1;
  logic [0:0][LOG-1:0] amtReadAddr1;
  logic [0:0][PL-1:0]  amtReadData1;
  logic repairFlag1, repairBusy1, repairDone1;
  logic [0:0][LOG-1:0] repairAddr1;
  logic [0:0][PL-1:0]  repairData1;
  logic [0:0]          laneValid1;
`ifdef REPAIR_PERF_CNT_EN
  logic [15:0] repairCount, repairCount1;
  logic [31:0] repairCycles, repairCycles1;
`endif

  logic [PL-1:0] amt [64];
  logic [PL-1:0] rmt [64];
  logic [N-1:0][PL-1:0] ramQ;
  logic [PL-1:0] ramQ1;

  int checks = 0;
  int fails  = 0;

  // reference model state: walk active, next beat to read, beat in flight
  bit mActive = 0;
  int mNext = 0;
  bit mPend = 0;
  int mPendBeat = 0;
  int mWalks = 0;
  int mBusyCycles = 0;

  rename_repair_sequencer #(
    .SIZE_RMT(SIZE_RMT), .SIZE_RMT_LOG(LOG), .SIZE_PHYSICAL_LOG(PL), .N_REPAIR_PACKETS(N)
  ) dut (
    .clk(clk), .reset_n(resetN), .recoverFlag_i(recoverFlag), .amtRamReady_i(amtRamReady),
    .amtReadEn_o(amtReadEn), .amtReadAddr_o(amtReadAddr), .amtReadData_i(amtReadData),
    .repairFlag_o(repairFlag), .repairAddr_o(repairAddr), .repairData_o(repairData),
    .repairLaneValid_o(laneValid), .repairBusy_o(repairBusy), .repairDone_o(repairDone)
`ifdef REPAIR_PERF_CNT_EN
    , .repairCount_o(repairCount), .repairCycles_o(repairCycles)
`endif
  );

  rename_repair_sequencer #(
    .SIZE_RMT(SIZE_RMT), .SIZE_RMT_LOG(LOG), .SIZE_PHYSICAL_LOG(PL), .N_REPAIR_PACKETS(1)
  ) dut1 (
    .clk(clk), .reset_n(resetN), .recoverFlag_i(recover1), .amtRamReady_i(ready1),
    .amtReadEn_o(amtReadEn1), .amtReadAddr_o(amtReadAddr1), .amtReadData_i(amtReadData1),
    .repairFlag_o(repairFlag1), .repairAddr_o(repairAddr1), .repairData_o(repairData1),
    .repairLaneValid_o(laneValid1), .repairBusy_o(repairBusy1), .repairDone_o(repairDone1)
`ifdef REPAIR_PERF_CNT_EN
    , .repairCount_o(repairCount1), .repairCycles_o(repairCycles1)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // AMT RAM model: data one cycle after the read strobe
  always @(posedge clk) begin
    if (amtReadEn) for (int k = 0; k < N; k++) ramQ[k] <= amt[amtReadAddr[k]];
    if (amtReadEn1) ramQ1 <= amt[amtReadAddr1[0]];
  end
  assign amtReadData  = ramQ;
  assign amtReadData1[0] = ramQ1;

  // RMT model: absorbs valid repair lanes
  always @(posedge clk) begin
    if (repairFlag)
      for (int k = 0; k < N; k++) if (laneValid[k]) rmt[repairAddr[k]] <= repairData[k];
  end

  function automatic int expAddr(input int beat, input int k);
    int a;
    a = beat * N + k;
    return (a < SIZE_RMT) ? a : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic randomizeAmt();
    for (int i = 0; i < 64; i++) amt[i] = PL'($urandom);
  endtask

  task automatic checkRmt(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < SIZE_RMT; i++) if (rmt[i] != amt[i]) bad++;
    check({name, " rmt entries differing from amt"}, bad, 0);
  endtask

  task automatic modelReset();
    mActive = 0; mNext = 0; mPend = 0; mPendBeat = 0; mWalks = 0; mBusyCycles = 0;
  endtask

  // One cycle: drive inputs after the edge, sample mid-cycle, compare with the model, advance it
  task automatic stepCycle(input bit rec, input bit rdy, input string tag, input int c);
    bit eRe, eBusy, eDone, eV;
    int a;
    @(posedge clk);
    #1;
    recoverFlag = rec;
    amtRamReady = rdy;
    #3;
    eRe   = mActive && rdy && !rec;
    eDone = mPend && (mPendBeat == BEATS - 1);
    eBusy = mActive || eDone;
    check($sformatf("%s c%0d readEn", tag, c), int'(amtReadEn), int'(eRe));
    for (int k = 0; k < N; k++) begin
      a = eRe ? expAddr(mNext, k) : 0;
      check($sformatf("%s c%0d readAddr%0d", tag, c, k), int'(amtReadAddr[k]), a);
    end
    check($sformatf("%s c%0d repairFlag", tag, c), int'(repairFlag), int'(mPend));
    check($sformatf("%s c%0d done", tag, c), int'(repairDone), int'(eDone));
    check($sformatf("%s c%0d busy", tag, c), int'(repairBusy), int'(eBusy));
    for (int k = 0; k < N; k++) begin
      a  = mPend ? expAddr(mPendBeat, k) : 0;
      eV = mPend && ((mPendBeat * N + k) < SIZE_RMT);
      check($sformatf("%s c%0d repairAddr%0d", tag, c, k), int'(repairAddr[k]), a);
      check($sformatf("%s c%0d laneValid%0d", tag, c, k), int'(laneValid[k]), int'(eV));
      if (eV) check($sformatf("%s c%0d repairData%0d", tag, c, k), int'(repairData[k]), int'(amt[a]));
    end
    if (eBusy) mBusyCycles++;
    mPend     = eRe;
    mPendBeat = mNext;
    if (eRe) begin
      mNext++;
      if (mNext == BEATS) mActive = 0;
    end
    if (rec) begin
      mActive = 1;
      mNext   = 0;
      mWalks++;
    end
  endtask

  typedef struct {
    bit rec;
    bit rdy;
    bit eReadEn;
    bit eFlag;
    bit eDone;
    bit eBusy;
    int eValid;
    int eAddr0;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int doneCnt, beats1, doneAt1;
    bit started;
    resetN = 0; recoverFlag = 0; amtRamReady = 1; recover1 = 0; ready1 = 1;
    randomizeAmt();
    for (int c = 0; c < 12; c++) begin
      tbl[c].rec     = (c == 0);
      tbl[c].rdy     = 1;
      tbl[c].eReadEn = (c >= 1 && c <= 9);
      tbl[c].eFlag   = (c >= 2 && c <= 10);
      tbl[c].eDone   = (c == 10);
      tbl[c].eBusy   = (c >= 1 && c <= 10);
      tbl[c].eValid  = (c == 10) ? 3 : (tbl[c].eFlag ? 15 : 0);
      tbl[c].eAddr0  = tbl[c].eFlag ? (c - 2) * 4 : 0;
    end

    repeat (2) @(posedge clk);
    #4;
    check("reset readEn", int'(amtReadEn), 0);
    check("reset readAddr", int'(amtReadAddr), 0);
    check("reset repairFlag", int'(repairFlag), 0);
    check("reset repairAddr", int'(repairAddr), 0);
    check("reset repairData", int'(repairData), 0);
    check("reset laneValid", int'(laneValid), 0);
    check("reset busy", int'(repairBusy), 0);
    check("reset done", int'(repairDone), 0);
    @(posedge clk);
    #1 resetN = 1;

    // basic walk from the table
    for (int c = 0; c < 12; c++) begin
      stepCycle(tbl[c].rec, tbl[c].rdy, "basic", c);
      check($sformatf("tbl c%0d readEn", c), int'(amtReadEn), int'(tbl[c].eReadEn));
      check($sformatf("tbl c%0d flag", c), int'(repairFlag), int'(tbl[c].eFlag));
      check($sformatf("tbl c%0d done", c), int'(repairDone), int'(tbl[c].eDone));
      check($sformatf("tbl c%0d busy", c), int'(repairBusy), int'(tbl[c].eBusy));
      check($sformatf("tbl c%0d laneValid", c), int'(laneValid), tbl[c].eValid);
      check($sformatf("tbl c%0d repairAddr0", c), int'(repairAddr[0]), tbl[c].eAddr0);
      if (c == 10) begin
        check("last beat addr1", int'(repairAddr[1]), 33);
        check("last beat addr2", int'(repairAddr[2]), 0);
        check("last beat addr3", int'(repairAddr[3]), 0);
      end
    end
    checkRmt("basic");
    for (int i = 0; i < 3; i++) stepCycle(0, 1, "idle", i);

    // RAM not ready at recover, raised at cycle 5
    randomizeAmt();
    doneCnt = 0;
    for (int c = 0; c < 17; c++) begin
      stepCycle(c == 0, c >= 5, "waitram", c);
      check($sformatf("waitram c%0d busy span", c), int'(repairBusy), int'(c >= 1 && c <= 14));
      check($sformatf("waitram c%0d readEn", c), int'(amtReadEn), int'(c >= 5 && c <= 13));
      check($sformatf("waitram c%0d done", c), int'(repairDone), int'(c == 14));
    end
    checkRmt("waitram");

    // second recover at cycle 4 restarts the walk
    randomizeAmt();
    for (int c = 0; c < 17; c++) begin
      stepCycle(c == 0 || c == 4, 1, "restart", c);
      if (repairDone) doneCnt++;
      if (c == 4) begin
        check("restart c4 flag", int'(repairFlag), 1);
        check("restart c4 addr0", int'(repairAddr[0]), 8);
      end
      if (c == 5) begin
        check("restart c5 readEn", int'(amtReadEn), 1);
        check("restart c5 addr0", int'(amtReadAddr[0]), 0);
      end
      check($sformatf("restart c%0d done", c), int'(repairDone), int'(c == 14));
    end
    check("restart done pulses", doneCnt, 1);
    checkRmt("restart");

    // async reset mid-walk
    for (int c = 0; c < 7; c++) stepCycle(c == 0, 1, "rstwalk", c);
    #1 resetN = 0;
    #1;
    check("async rst readEn", int'(amtReadEn), 0);
    check("async rst readAddr", int'(amtReadAddr), 0);
    check("async rst flag", int'(repairFlag), 0);
    check("async rst repairAddr", int'(repairAddr), 0);
    check("async rst laneValid", int'(laneValid), 0);
    check("async rst busy", int'(repairBusy), 0);
    check("async rst done", int'(repairDone), 0);
    modelReset();
    @(posedge clk);
    #1 resetN = 1;
    randomizeAmt();
    for (int c = 0; c < 12; c++) begin
      stepCycle(c == 0, 1, "postrst", c);
      if (c == 1) begin
        check("postrst c1 readEn", int'(amtReadEn), 1);
        check("postrst c1 addr0", int'(amtReadAddr[0]), 0);
      end
    end
    checkRmt("postrst");

    // randomized recover / ready traffic against the model
    randomizeAmt();
    started = 0;
    for (int c = 0; c < 400; c++) begin
      bit r;
      r = ($urandom_range(0, 99) < 4);
      if (r) started = 1;
      stepCycle(r, $urandom_range(0, 99) < 80, "rand", c);
    end
    for (int c = 0; c < 15; c++) stepCycle(0, 1, "randdrain", c);
    if (started) checkRmt("rand");
`ifdef REPAIR_PERF_CNT_EN
    check("perf walks", int'(repairCount), mWalks);
    check("perf cycles", int'(repairCycles), mBusyCycles);
`endif

    // single-lane instance: 34 beats, done on the 34th beat
    beats1 = 0;
    doneAt1 = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 recover1 = (c == 0);
      #3;
      if (repairFlag1) begin
        check($sformatf("n1 beat%0d valid", beats1), int'(laneValid1[0]), 1);
        check($sformatf("n1 beat%0d addr", beats1), int'(repairAddr1[0]), beats1);
        check($sformatf("n1 beat%0d data", beats1), int'(repairData1[0]), int'(amt[beats1 % 64]));
        beats1++;
      end
      if (repairDone1) doneAt1 = c;
    end
    check("n1 beat count", beats1, 34);
    check("n1 done cycle", doneAt1, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rename_repair_sequencer.md
Name: rename_repair_sequencer

Overview:
Sequences restoration of the RenameMapTable after a pipeline recovery.
- On a recover request it walks every logical register, reading the architectural map table (AMT) N_REPAIR_PACKETS entries per cycle.
- It forwards each read beat to the RMT as repair packets (repairFlag/repairAddr/repairData).
- It holds rename busy until the walk completes.
- It sits between commit/recovery control, the AMT RAM and the Rename stage.

Parameters:
SIZE_RMT, 34, number of logical registers (RMT entries)
SIZE_RMT_LOG, 6, address width, ceil(log2(SIZE_RMT))
SIZE_PHYSICAL_LOG, 7, physical register tag width
N_REPAIR_PACKETS, 4, repair lanes per cycle (power of 2, >=1)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous, active-low reset
recoverFlag_i  in  1  single-cycle recovery request from commit
amtRamReady_i  in  1  AMT RAM initialised and readable
amtReadEn_o  out  1  AMT read strobe
amtReadAddr_o  out  N_REPAIR_PACKETS x SIZE_RMT_LOG  AMT read addresses
amtReadData_i  in  N_REPAIR_PACKETS x SIZE_PHYSICAL_LOG  AMT data, valid one cycle after amtReadEn_o
repairFlag_o  out  1  repair beat valid to RMT
repairAddr_o  out  N_REPAIR_PACKETS x SIZE_RMT_LOG  RMT write addresses
repairData_o  out  N_REPAIR_PACKETS x SIZE_PHYSICAL_LOG  RMT write data
repairLaneValid_o  out  N_REPAIR_PACKETS  per-lane write enable (masks lanes past SIZE_RMT)
repairBusy_o  out  1  walk in progress; Rename must stall
repairDone_o  out  1  single-cycle pulse with last repair beat

Behaviour:
Reset values:
- All outputs 0; state IDLE; walk counter 0.

Constants:
- BEATS = ceil(SIZE_RMT / N_REPAIR_PACKETS).
- Counter width = ceil(log2(BEATS + 1)).

States: IDLE, WAIT_RAM, READ, DRAIN.

IDLE:
- recoverFlag_i -> READ if amtRamReady_i, else WAIT_RAM.
- Counter cleared.

WAIT_RAM:
- No reads issued.
- Go to READ on the first cycle amtRamReady_i = 1.

READ:
- amtReadEn_o = 1.
- amtReadAddr_o[k] = beat*N + k for beat 0..BEATS-1.
- Out-of-range addresses are driven as 0.
- Counter increments each cycle.
- After the beat BEATS-1 read is issued -> DRAIN.

Repair pipeline:
- Registered address/lane-valid stage, 1-cycle latency.
- Cycle after each read: repairFlag_o = 1, repairAddr_o = registered addresses, repairData_o = amtReadData_i.
- repairLaneValid_o[k] = (addr < SIZE_RMT).
- repairFlag_o is 1 on every beat, including partial beats.

DRAIN:
- Emits the final repair beat with repairDone_o = 1 -> IDLE.

repairBusy_o:
- 1 in WAIT_RAM, READ and DRAIN.
- Therefore 1 from the cycle after recoverFlag_i through the repairDone_o cycle.
- No-wait walk: busy for BEATS + 1 cycles.

recoverFlag_i while busy:
- Restart: counter -> 0, state -> READ (or WAIT_RAM).
- Any repair beat already in flight is still emitted; it carries correct AMT data.
- repairDone_o is not pulsed for the aborted walk.

amtRamReady_i falls during READ:
- Return to WAIT_RAM; the counter holds.
- The beat in flight drains.
- Resume at the held beat.

Async reset mid-walk:
- Immediate IDLE; all outputs 0.
- No done pulse.

Optional Feature:
REPAIR_PERF_CNT_EN
- Defined: adds outputs repairCount_o (16 bit, walks started, saturating) and repairCycles_o (32 bit, cycles with repairBusy_o = 1, saturating). Both are reset to 0 by reset_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
Shared package:
- repairPkt struct {addr, data, valid}.
- Repair state enum.
- BEATS constant function.
- Counter widths derived from the parameters.

One natural sub-module, repair_addr_gen: beat counter -> lane addresses and lane-valid mask.
- Reused by the AMT walk and the bench checker.
- FSM and pipeline register stay in the top module.

Test Plan:
- Default params, amtRamReady_i = 1, recoverFlag_i pulse at cycle 0 -> amtReadEn_o cycles 1-9; repairFlag_o cycles 2-10; repairDone_o cycle 10 only; repairBusy_o cycles 1-10; RMT contents equal AMT for regs 0-33.
- Last beat (beat 8) -> repairAddr_o = {32,33,0,0}, repairLaneValid_o = 4'b0011.
- amtRamReady_i = 0 at recover, raised at cycle 5 -> first read cycle 5, repairDone_o cycle 14, busy cycles 1-14.
- Second recoverFlag_i at cycle 4 -> beat-2 repair emitted cycle 4, reads restart at address 0 cycle 5, single repairDone_o at cycle 14.
- reset_n asserted at cycle 6 mid-walk -> all outputs 0 asynchronously; after release, recoverFlag_i starts a clean walk from address 0.
- N_REPAIR_PACKETS = 1, SIZE_RMT = 34 -> 34 repair beats, lane valid always 1, repairDone_o on beat 34 (cycle 35).
